// File: rtl/prog_loader_if.sv
// Host byte stream, memory write/readback port and CPU control bundle for prog_loader.
// master = host/memory side, slave = loader side.
interface prog_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic [DATA_W-1:0] mem_rdata;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [2:0]        dbg_state;

   // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
   // byte_valid held while byte_ready is low keeps the byte pending, never dropped.
   modport master (
      output start, byte_in, byte_valid, mem_rdata,
      input  byte_ready, mem_we, mem_addr, mem_wdata, mem_rd, cpu_hold, done, err, dbg_state
   );

   modport slave (
      input  start, byte_in, byte_valid, mem_rdata,
      output byte_ready, mem_we, mem_addr, mem_wdata, mem_rd, cpu_hold, done, err, dbg_state
   );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream program loader (length, payload, checksum) that writes memory and gates CPU reset.
// Optional write-then-verify readback is enabled by defining PROG_LOADER_READBACK_EN.
module prog_loader #(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic         clk,
   input  logic         reset,
   prog_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN    = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
`ifdef PROG_LOADER_READBACK_EN
      ,
      S_WR     = 3'd6,
      S_VERIFY = 3'd7
`endif
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] len_q;
   logic [DATA_W-1:0] cnt_q;
   logic [DATA_W-1:0] sum_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_we_q;
   logic              cpu_hold_q;
   logic              done_q;
   logic              err_q;

   logic [DATA_W-1:0] cnt_d;
   logic [DATA_W-1:0] sum_d;
   logic [ADDR_W-1:0] addr_d;
   logic              accept;

   assign bus.byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign accept         = bus.byte_valid && bus.byte_ready;

   // Length byte 0 means a full 2^DATA_W frame: cnt wraps to 0 exactly on the last byte.
   assign cnt_d  = cnt_q + 1'b1;
   assign sum_d  = sum_q + bus.byte_in;
   assign addr_d = BASE_ADDR + ADDR_W'(cnt_q);

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_hold  = cpu_hold_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.dbg_state = state_q;

`ifdef PROG_LOADER_READBACK_EN
   logic mem_rd_q;
   assign bus.mem_rd = mem_rd_q;
`else
   logic unused_rdata;
   assign bus.mem_rd   = 1'b0;
   assign unused_rdata = ^bus.mem_rdata;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         cpu_hold_q  <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef PROG_LOADER_READBACK_EN
         mem_rd_q    <= 1'b0;
`endif
      end else begin
         mem_we_q <= 1'b0;
`ifdef PROG_LOADER_READBACK_EN
         mem_rd_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (bus.start) state_q <= S_LEN;
            end
            S_LEN: begin
               if (accept) begin
                  len_q   <= bus.byte_in;
                  cnt_q   <= '0;
                  sum_q   <= '0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (accept) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_d;
                  mem_wdata_q <= bus.byte_in;
                  cnt_q       <= cnt_d;
                  sum_q       <= sum_d;
`ifdef PROG_LOADER_READBACK_EN
                  state_q     <= S_WR;
`else
                  if (cnt_d == len_q) state_q <= S_CSUM;
`endif
               end
            end
`ifdef PROG_LOADER_READBACK_EN
            S_WR: begin
               // Address and data stay registered so the read targets the word just written.
               mem_rd_q <= 1'b1;
               state_q  <= S_VERIFY;
            end
            S_VERIFY: begin
               if (bus.mem_rdata != mem_wdata_q) begin
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else if (cnt_q == len_q) begin
                  state_q <= S_CSUM;
               end else begin
                  state_q <= S_DATA;
               end
            end
`endif
            S_CSUM: begin
               if (accept) begin
                  if (bus.byte_in == sum_q) begin
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                     state_q    <= S_DONE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
            S_DONE, S_ERR: begin
               if (bus.start) begin
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  cpu_hold_q <= 1'b1;
                  state_q    <= S_LEN;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
